// File: rtl/input_buffer_pkg.sv
// Shared definitions for the input buffer port: parser state encoding and frame defaults.
package input_buffer_pkg;

    // Default payload capacity; must agree with word2bit_trans_unit.
    localparam int unsigned MAX_CHANNEL_NUM_DEFAULT = 128;
    // Default frame start marker.
    localparam logic [7:0]  SYNC_BYTE_DEFAULT       = 8'hA5;

    typedef logic [2:0] parser_state_t;

    localparam parser_state_t ST_IDLE     = 3'd0;
    localparam parser_state_t ST_LEN      = 3'd1;
    localparam parser_state_t ST_PAYLOAD  = 3'd2;
    localparam parser_state_t ST_CHK      = 3'd3;
    localparam parser_state_t ST_WAIT_ACK = 3'd4;

endpackage

// File: rtl/input_packet_parser.sv
// Frame parser in front of word2bit_trans_unit: strips SYNC/LEN/CHK, forwards the payload one
// byte per strobe, and holds the link off until the transposer releases its buffer.
module input_packet_parser
    import input_buffer_pkg::*;
#(
    parameter int unsigned MAX_CHANNEL_NUM = MAX_CHANNEL_NUM_DEFAULT,
    parameter logic [7:0]  SYNC_BYTE       = SYNC_BYTE_DEFAULT,
    localparam int unsigned CW             = $clog2(MAX_CHANNEL_NUM)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_vld_i,
    output logic          rx_rdy_o,
    output logic [7:0]    wordser_data_o,
    output logic          wordser_data_vld_o,
    output logic [CW-1:0] channel_num_o,
    output logic          new_packet_o,
    input  logic          packet_received_i,
    input  logic          trans_done_i,
    output logic          err_len_o,
    output logic          err_chk_o,
    output logic [15:0]   pkt_cnt_o
);

    // Largest legal LEN byte, widened so MAX_CHANNEL_NUM=256 does not overflow.
    localparam logic [8:0] LEN_MAX = 9'(MAX_CHANNEL_NUM - 1);

    parser_state_t state_q, state_d;
    logic [CW-1:0] chan_q, chan_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    acc_q, acc_d;
    logic [7:0]    data_q, data_d;
    logic          vld_q, vld_d;
    logic          new_pkt_q, new_pkt_d;
    logic          err_len_q, err_len_d;
    logic          err_chk_q, err_chk_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;

    logic fire;
    logic len_ok;

    assign fire   = rx_vld_i && rx_rdy_o;
    assign len_ok = ({1'b0, rx_data_i} <= LEN_MAX);

    // Link ready per state; payload is gated so nothing reaches a transposer still holding data.
    always_comb begin
        rx_rdy_o = 1'b0;
        case (state_q)
            ST_IDLE, ST_LEN, ST_CHK: rx_rdy_o = 1'b1;
            ST_PAYLOAD:              rx_rdy_o = !packet_received_i;
            default:                 rx_rdy_o = 1'b0;
        endcase
    end

    // Next-state and datapath: frame walk, XOR accumulation, one-cycle pulses.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        new_pkt_d = 1'b0;
        err_len_d = 1'b0;
        err_chk_d = 1'b0;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Non-sync bytes are dropped while hunting.
                if (fire && (rx_data_i == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (fire) begin
                    if (len_ok) begin
                        chan_d  = rx_data_i[CW-1:0];
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (fire) begin
                    data_d = rx_data_i;
                    vld_d  = 1'b1;
                    acc_d  = acc_q ^ rx_data_i;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == chan_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                // Payload is already with the transposer, so a bad checksum only flags.
                if (fire) begin
                    err_chk_d = (rx_data_i != acc_q);
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (packet_received_i) begin
                    new_pkt_d = 1'b1;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            chan_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            new_pkt_q <= 1'b0;
            err_len_q <= 1'b0;
            err_chk_q <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            new_pkt_q <= new_pkt_d;
            err_len_q <= err_len_d;
            err_chk_q <= err_chk_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign wordser_data_o     = data_q;
    assign wordser_data_vld_o = vld_q;
    assign channel_num_o      = chan_q;
    assign new_packet_o       = new_pkt_q;
    assign err_len_o          = err_len_q;
    assign err_chk_o          = err_chk_q;
    assign pkt_cnt_o          = pkt_cnt_q;

    // The transposer must report the full payload captured by the cycle after WAIT_ACK starts.
    a_trans_done_after_wait: assert property (@(posedge clk_i) disable iff (rst_i)
        ((state_q == ST_WAIT_ACK) && ($past(state_q) != ST_WAIT_ACK)) |=> trans_done_i);

endmodule

// File: tb/tb_input_packet_parser.sv
// Self-checking bench for input_packet_parser with a small behavioural transposer attached.
module tb_input_packet_parser;
    import input_buffer_pkg::*;

    localparam int unsigned MAXC = 128;
    localparam int unsigned CW   = $clog2(MAXC);
    localparam logic [7:0]  SYNC = 8'hA5;

    typedef logic [7:0] byte_q_t [$];

    typedef struct {
        int              n;
        logic [7:0][7:0] b;       // byte k of the frame is b[7-k]
        int              gap;     // 1: random idle cycles between bytes
        int              pay_at;  // index of first payload byte
        int              exp_ch;
        int              exp_strobes;
        int              exp_le;
        int              exp_ce;
        int              exp_pkts;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [7:0]    rx_data_i;
    logic          rx_vld_i;
    logic          rx_rdy_o;
    logic [7:0]    wordser_data_o;
    logic          wordser_data_vld_o;
    logic [CW-1:0] channel_num_o;
    logic          new_packet_o;
    logic          packet_received_i;
    logic          trans_done_i;
    logic          err_len_o;
    logic          err_chk_o;
    logic [15:0]   pkt_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state (written only by the monitor process).
    byte_q_t got_q;
    int      n_len_err = 0;
    int      n_chk_err = 0;
    int      n_newpkt  = 0;
    int      n_viol    = 0;

    // Transposer model state.
    logic [7:0] tmem [MAXC];
    int         t_wcnt;
    int         t_planes;

    int exp_pkt_total = 0;

    always #5 clk_i = ~clk_i;

    input_packet_parser #(
        .MAX_CHANNEL_NUM (MAXC),
        .SYNC_BYTE       (SYNC)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .rx_data_i          (rx_data_i),
        .rx_vld_i           (rx_vld_i),
        .rx_rdy_o           (rx_rdy_o),
        .wordser_data_o     (wordser_data_o),
        .wordser_data_vld_o (wordser_data_vld_o),
        .channel_num_o      (channel_num_o),
        .new_packet_o       (new_packet_o),
        .packet_received_i  (packet_received_i),
        .trans_done_i       (trans_done_i),
        .err_len_o          (err_len_o),
        .err_chk_o          (err_chk_o),
        .pkt_cnt_o          (pkt_cnt_o)
    );

    // Behavioural transposer: captures channel_num+1 bytes, then 8 plane cycles, then holds.
    always @(posedge clk_i) begin
        if (rst_i) begin
            t_wcnt            <= 0;
            t_planes          <= 0;
            trans_done_i      <= 1'b0;
            packet_received_i <= 1'b0;
        end else if (new_packet_o) begin
            t_wcnt            <= 0;
            t_planes          <= 0;
            trans_done_i      <= 1'b0;
            packet_received_i <= 1'b0;
        end else if (!trans_done_i) begin
            if (wordser_data_vld_o) begin
                tmem[t_wcnt] <= wordser_data_o;
                if (t_wcnt == int'(channel_num_o)) begin
                    trans_done_i <= 1'b1;
                    t_wcnt       <= 0;
                end else begin
                    t_wcnt <= t_wcnt + 1;
                end
            end
        end else if (!packet_received_i) begin
            if (t_planes == 7) packet_received_i <= 1'b1;
            t_planes <= t_planes + 1;
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (wordser_data_vld_o) begin
                got_q.push_back(wordser_data_o);
                if (packet_received_i) n_viol <= n_viol + 1;
            end
            if (err_len_o)    n_len_err <= n_len_err + 1;
            if (err_chk_o)    n_chk_err <= n_chk_err + 1;
            if (new_packet_o) n_newpkt  <= n_newpkt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        repeat (gap) begin
            rx_vld_i  = 1'b0;
            rx_data_i = 8'($urandom);
            @(posedge clk_i);
            #1;
        end
        rx_vld_i  = 1'b1;
        rx_data_i = b;
        @(negedge clk_i);
        while (!rx_rdy_o && waited < 3000) begin
            @(negedge clk_i);
            waited++;
        end
        if (!rx_rdy_o) begin
            n_checks++;
            $display("FAIL send_timeout: rx_rdy_o stuck at 0, byte %0h not accepted", b);
        end
        @(posedge clk_i);
        #1;
        rx_vld_i  = 1'b0;
        rx_data_i = 8'($urandom);
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int w;
        w = 0;
        while (n_newpkt < target && w < budget) begin
            @(posedge clk_i);
            #1;
            w++;
        end
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    // Reference parser over a whole byte stream, straight from the frame format.
    function automatic void ref_parse(input byte_q_t s, output byte_q_t pay,
                                      output int n_pkt, output int n_le, output int n_ce);
        int         i;
        int         len;
        logic [7:0] x;
        i = 0; n_pkt = 0; n_le = 0; n_ce = 0; pay = {};
        while (i < s.size()) begin
            if (s[i] != SYNC) begin
                i++;
                continue;
            end
            if (i + 1 >= s.size()) break;
            len = int'(s[i+1]);
            i += 2;
            if (len > int'(MAXC) - 1) begin
                n_le++;
                continue;
            end
            x = 8'h00;
            for (int k = 0; k <= len; k++) begin
                pay.push_back(s[i+k]);
                x = x ^ s[i+k];
            end
            i += len + 1;
            if (s[i] != x) n_ce++;
            i++;
            n_pkt++;
        end
    endfunction

    function automatic int q_mismatch(input byte_q_t exp, input int base);
        int m;
        m = 0;
        if (got_q.size() - base != exp.size()) m++;
        for (int k = 0; k < exp.size(); k++) begin
            if (base + k >= got_q.size()) m++;
            else if (got_q[base+k] !== exp[k]) m++;
        end
        return m;
    endfunction

    vec_t vecs [8];

    initial begin
        int      base_b, base_le, base_ce, base_np, waited;
        logic    rdy_seen;
        byte_q_t stream, pay_exp, pay2;
        int      m_pkt, m_le, m_ce, m;

        vecs[0] = '{7, {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h00}, 0, 2, 3, 4, 0, 0, 1};
        vecs[1] = '{4, {8'hA5, 8'h00, 8'h5A, 8'h00, 32'h0}, 1, 2, 0, 1, 0, 1, 1};
        vecs[2] = '{2, {8'hA5, 8'h80, 48'h0}, 0, 0, 0, 0, 1, 0, 0};
        vecs[3] = '{4, {8'hA5, 8'h00, 8'h01, 8'h01, 32'h0}, 0, 2, 0, 1, 0, 0, 1};
        vecs[4] = '{7, {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F, 8'h01, 8'h00}, 1, 4, 1, 2, 0, 0, 1};
        vecs[5] = '{2, {8'hA5, 8'hFF, 48'h0}, 1, 0, 1, 0, 1, 0, 0};
        vecs[6] = '{5, {8'h5A, 8'hA5, 8'h00, 8'hA5, 8'hA5, 24'h0}, 1, 3, 0, 1, 0, 0, 1};
        vecs[7] = '{2, {8'hA5, 8'hA5, 48'h0}, 0, 0, 0, 0, 1, 0, 0};

        rst_i     = 1'b1;
        rx_vld_i  = 1'b0;
        rx_data_i = 8'h00;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_outputs", 64'({wordser_data_o, wordser_data_vld_o, channel_num_o, new_packet_o,
              err_len_o, err_chk_o, pkt_cnt_o}), 64'd0);
        check("reset_rx_rdy", 64'(rx_rdy_o), 64'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Table-driven short frames.
        for (int v = 0; v < 8; v++) begin
            base_b  = got_q.size();
            base_le = n_len_err;
            base_ce = n_chk_err;
            base_np = n_newpkt;
            for (int k = 0; k < vecs[v].n; k++) begin
                send_byte(vecs[v].b[7-k], (vecs[v].gap != 0) ? int'($urandom_range(0, 3)) : 0);
            end
            if (vecs[v].exp_pkts != 0) begin
                rdy_seen = 1'b0;
                waited   = 0;
                @(negedge clk_i);
                while (!new_packet_o && waited < 200) begin
                    if (rx_rdy_o) rdy_seen = 1'b1;
                    @(negedge clk_i);
                    waited++;
                end
                check($sformatf("v%0d_rdy_low_in_wait", v), 64'(rdy_seen), 64'd0);
                check($sformatf("v%0d_release", v), 64'(new_packet_o), 64'd1);
            end
            repeat (3) @(posedge clk_i);
            #1;
            exp_pkt_total += vecs[v].exp_pkts;
            check($sformatf("v%0d_strobes", v), 64'(got_q.size() - base_b), 64'(vecs[v].exp_strobes));
            for (int k = 0; k < vecs[v].exp_strobes; k++) begin
                check($sformatf("v%0d_byte%0d", v, k),
                      (base_b + k < got_q.size()) ? 64'(got_q[base_b+k]) : 64'hDEAD,
                      64'(vecs[v].b[7-(vecs[v].pay_at+k)]));
            end
            check($sformatf("v%0d_err_len", v), 64'(n_len_err - base_le), 64'(vecs[v].exp_le));
            check($sformatf("v%0d_err_chk", v), 64'(n_chk_err - base_ce), 64'(vecs[v].exp_ce));
            check($sformatf("v%0d_new_pkt", v), 64'(n_newpkt - base_np), 64'(vecs[v].exp_pkts));
            check($sformatf("v%0d_channel_num", v), 64'(channel_num_o), 64'(vecs[v].exp_ch));
            check($sformatf("v%0d_pkt_cnt", v), 64'(pkt_cnt_o), 64'(16'(exp_pkt_total)));
        end

        // Back-to-back full-size frames, sent without idle cycles.
        stream = {};
        pay2   = {};
        for (int f = 0; f < 2; f++) begin
            logic [7:0] x, b;
            x = 8'h00;
            stream.push_back(SYNC);
            stream.push_back(8'(MAXC - 1));
            for (int k = 0; k < int'(MAXC); k++) begin
                b = 8'($urandom);
                x = x ^ b;
                stream.push_back(b);
                if (f == 1) pay2.push_back(b);
            end
            stream.push_back(x);
        end
        ref_parse(stream, pay_exp, m_pkt, m_le, m_ce);
        base_b  = got_q.size();
        base_np = n_newpkt;
        base_ce = n_chk_err;
        foreach (stream[i]) send_byte(stream[i], 0);
        wait_pkts(base_np + m_pkt, 3000);
        exp_pkt_total += m_pkt;
        check("b2b_bytes_mismatch", 64'(q_mismatch(pay_exp, base_b)), 64'd0);
        check("b2b_new_pkt", 64'(n_newpkt - base_np), 64'(m_pkt));
        check("b2b_err_chk", 64'(n_chk_err - base_ce), 64'(m_ce));
        check("b2b_channel_num", 64'(channel_num_o), 64'(MAXC - 1));
        for (int p = 0; p < 8; p++) begin
            logic [MAXC-1:0] exp_plane, got_plane;
            for (int i = 0; i < int'(MAXC); i++) begin
                exp_plane[i] = pay2[i][p];
                got_plane[i] = tmem[i][p];
            end
            check($sformatf("b2b_plane%0d_ok", p), 64'(got_plane == exp_plane), 64'd1);
        end
        check("no_strobe_while_received", 64'(n_viol), 64'd0);

        // Randomized frames against the reference parser.
        stream = {};
        for (int f = 0; f < 30; f++) begin
            int         kind, len;
            logic [7:0] x, b;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                stream.push_back(b);
            end
            stream.push_back(SYNC);
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                stream.push_back(8'($urandom_range(MAXC, 255)));
            end else begin
                len = (kind == 1) ? int'(MAXC - 1) : int'($urandom_range(0, 15));
                stream.push_back(8'(len));
                x = 8'h00;
                for (int k = 0; k <= len; k++) begin
                    b = 8'($urandom);
                    x = x ^ b;
                    stream.push_back(b);
                end
                if (kind == 2 || kind == 3) x = x ^ 8'($urandom_range(1, 255));
                stream.push_back(x);
            end
        end
        ref_parse(stream, pay_exp, m_pkt, m_le, m_ce);
        base_b  = got_q.size();
        base_le = n_len_err;
        base_ce = n_chk_err;
        base_np = n_newpkt;
        foreach (stream[i]) send_byte(stream[i], int'($urandom_range(0, 2)));
        wait_pkts(base_np + m_pkt, 3000);
        exp_pkt_total += m_pkt;
        check("rand_bytes_mismatch", 64'(q_mismatch(pay_exp, base_b)), 64'd0);
        check("rand_err_len", 64'(n_len_err - base_le), 64'(m_le));
        check("rand_err_chk", 64'(n_chk_err - base_ce), 64'(m_ce));
        check("rand_new_pkt", 64'(n_newpkt - base_np), 64'(m_pkt));
        check("rand_pkt_cnt", 64'(pkt_cnt_o), 64'(16'(exp_pkt_total)));

        // Reset after 5 of 8 payload bytes.
        send_byte(SYNC, 0);
        send_byte(8'h07, 0);
        for (int k = 0; k < 5; k++) send_byte(8'($urandom), 0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("midreset_outputs", 64'({wordser_data_o, wordser_data_vld_o, channel_num_o,
              new_packet_o, err_len_o, err_chk_o, pkt_cnt_o}), 64'd0);
        check("midreset_rx_rdy", 64'(rx_rdy_o), 64'd1);
        rst_i = 1'b0;
        exp_pkt_total = 0;
        @(posedge clk_i);
        #1;
        stream  = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30, 8'h00};
        ref_parse(stream, pay_exp, m_pkt, m_le, m_ce);
        base_b  = got_q.size();
        base_le = n_len_err;
        base_ce = n_chk_err;
        base_np = n_newpkt;
        foreach (stream[i]) send_byte(stream[i], 0);
        wait_pkts(base_np + 1, 300);
        check("post_reset_bytes_mismatch", 64'(q_mismatch(pay_exp, base_b)), 64'd0);
        check("post_reset_errors", 64'((n_len_err - base_le) + (n_chk_err - base_ce)), 64'd0);
        check("post_reset_channel_num", 64'(channel_num_o), 64'd2);
        check("post_reset_pkt_cnt", 64'(pkt_cnt_o), 64'd1);
        check("final_no_strobe_while_received", 64'(n_viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
